// File: rtl/color_fsm_pkg.sv
// rtl/color_fsm_pkg.sv - shared command encoding and sizing helpers for the colour sequencer
package color_fsm_pkg;

   typedef enum logic [1:0] {
      CMD_HOLD    = 2'd0,
      CMD_STEP    = 2'd1,
      CMD_AUTO    = 2'd2,
      CMD_RESTART = 2'd3
   } cmd_t;

   localparam int TRACE_WIDTH = 16;

   // State index width; a two-state machine still needs one bit.
   function automatic int state_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/color_dwell_timer.sv
// rtl/color_dwell_timer.sv - per-state dwell timer; expired while timer >= live dwell
module color_dwell_timer
#(
   parameter int DWELL_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   en,
   input  logic [DWELL_WIDTH-1:0] dwell,
   output logic                   expired
);

   logic [DWELL_WIDTH-1:0] timer_q;
   logic [DWELL_WIDTH-1:0] timer_d;

   // Compare against the live dwell so lowering it mid-state expires at once.
   assign expired = (timer_q >= dwell);

   always_comb begin
      timer_d = timer_q;
      if (clear) begin
         timer_d = '0;
      end else if (en) begin
         timer_d = expired ? '0 : timer_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end

endmodule

// File: rtl/color_seq_fsm.sv
// rtl/color_seq_fsm.sv - N-state Moore colour sequencer with dwell timer and change strobe
// Optional transition counter on trans_count when COLOR_FSM_TRACE_EN is defined.
module color_seq_fsm
   import color_fsm_pkg::*;
#(
   parameter int NUM_STATES  = 4,
   parameter int OUT_WIDTH   = 2,
   parameter int DWELL_WIDTH = 8,
   parameter int INIT_STATE  = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [1:0]                       in,
   input  logic [DWELL_WIDTH-1:0]           dwell,
   output logic [OUT_WIDTH-1:0]             out,
   output logic [state_w(NUM_STATES)-1:0]   state_idx,
   output logic                             state_change
`ifdef COLOR_FSM_TRACE_EN
   ,
   output logic [TRACE_WIDTH-1:0]           trans_count
`endif
);

   localparam int SW = state_w(NUM_STATES);
   localparam logic [SW-1:0] ZERO_S = '0;
   localparam logic [SW-1:0] INIT_S = SW'(INIT_STATE);
   localparam logic [SW-1:0] PREV_S = SW'(NUM_STATES - 2);
   localparam logic [SW-1:0] LAST_S = SW'(NUM_STATES - 1);

   cmd_t          cmd;
   logic [SW-1:0] state_q;
   logic [SW-1:0] state_d;
   logic [SW-1:0] succ;
   logic          valid;
   logic          change_q;
   logic          expired;

   assign cmd = cmd_t'(in);

   color_dwell_timer #(
      .DWELL_WIDTH (DWELL_WIDTH)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   ((cmd == CMD_STEP) || (cmd == CMD_RESTART)),
      .en      (cmd == CMD_AUTO),
      .dwell   (dwell),
      .expired (expired)
   );

   // Indices past LAST_S are soft errors and recover to INIT_S regardless of command.
   always_comb begin
      state_d = state_q;
      succ    = INIT_S;
      valid   = 1'b1;
      unique case (state_q) inside
         [ZERO_S:PREV_S]: succ = state_q + 1'b1;
         LAST_S:          succ = ZERO_S;
         default:         valid = 1'b0;
      endcase
      if (!valid) begin
         state_d = INIT_S;
      end else begin
         case (cmd)
            CMD_STEP:    state_d = succ;
            CMD_AUTO:    if (expired) state_d = succ;
            CMD_RESTART: state_d = INIT_S;
            default:     state_d = state_q;
         endcase
      end
   end

   always_comb begin
      out = OUT_WIDTH'(INIT_STATE + 1);
      unique case (state_q) inside
         [ZERO_S:LAST_S]: out = OUT_WIDTH'(32'(state_q) + 32'd1);
         default:         out = OUT_WIDTH'(INIT_STATE + 1);
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= INIT_S;
         change_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         change_q <= (state_d != state_q);
      end
   end

   assign state_idx    = state_q;
   assign state_change = change_q;

`ifdef COLOR_FSM_TRACE_EN
   logic [TRACE_WIDTH-1:0] trans_q;

   // RESTART zeroes the count and its own transition is deliberately not counted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trans_q <= '0;
      end else if (cmd == CMD_RESTART) begin
         trans_q <= '0;
      end else if ((state_d != state_q) && (trans_q != '1)) begin
         trans_q <= trans_q + 1'b1;
      end
   end

   assign trans_count = trans_q;
`endif

endmodule
